// File: rtl/ara_xif_issue_queue_if.sv
// XIF issue/commit bundle between the scalar core (master) and Ara's issue queue (slave).
interface ara_xif_issue_queue_if #(
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned InstrWidth = 32
);
    logic                  issue_valid;
    logic                  issue_ready;
    logic [InstrWidth-1:0] issue_instr;
    logic [IdWidth-1:0]    issue_id;
    logic                  issue_accept;
    logic                  issue_writeback;
    logic [1:0]            issue_register_read;
    logic                  issue_is_vfp;

    logic                  commit_valid;
    logic [IdWidth-1:0]    commit_id;
    logic                  commit_kill;
    logic                  commit_err;

    modport master (
        output issue_valid,
        output issue_instr,
        output issue_id,
        output commit_valid,
        output commit_id,
        output commit_kill,
        input  issue_ready,
        input  issue_accept,
        input  issue_writeback,
        input  issue_register_read,
        input  issue_is_vfp,
        input  commit_err
    );

    modport slave (
        input  issue_valid,
        input  issue_instr,
        input  issue_id,
        input  commit_valid,
        input  commit_id,
        input  commit_kill,
        output issue_ready,
        output issue_accept,
        output issue_writeback,
        output issue_register_read,
        output issue_is_vfp,
        output commit_err
    );
endinterface

// File: rtl/ara_xif_issue_queue.sv
// XIF predecoder plus in-order issue queue waiting on commit/kill before dispatch to the sequencer.
// Define ARA_XIF_ISSUE_VCSR_EN to accept SYSTEM-opcode accesses to the vector CSRs.
module ara_xif_issue_queue #(
    parameter int unsigned NrEntries  = 4,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned InstrWidth = 32,
    localparam int unsigned PtrWidth  = $clog2(NrEntries),
    localparam int unsigned CntWidth  = PtrWidth + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ara_xif_issue_queue_if.slave  xif,
    output logic                  disp_valid_o,
    input  logic                  disp_ready_i,
    output logic [InstrWidth-1:0] disp_instr_o,
    output logic [IdWidth-1:0]    disp_id_o,
    output logic                  disp_is_vfp_o,
    output logic [CntWidth-1:0]   occupancy_o
);

    localparam logic [6:0] OpcodeVec     = 7'h57;
    localparam logic [6:0] OpcodeLoadFp  = 7'h07;
    localparam logic [6:0] OpcodeStoreFp = 7'h27;
    localparam logic [6:0] OpcodeAmo     = 7'h2F;

    localparam logic [2:0] Opfvv = 3'b001;
    localparam logic [2:0] Opmvv = 3'b010;
    localparam logic [2:0] Opivx = 3'b100;
    localparam logic [2:0] Opfvf = 3'b101;
    localparam logic [2:0] Opmvx = 3'b110;
    localparam logic [2:0] Opcfg = 3'b111;

    typedef enum logic [1:0] {
        StFree,
        StWait,
        StCommitted,
        StKilled
    } entry_state_e;

    // ---------------------------------------------------------------------------------------------
    // Predecode
    // ---------------------------------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [5:0]  funct6;
    logic        width_ok;
    logic        dec_accept;
    logic        dec_writeback;
    logic [1:0]  dec_read;
    logic        dec_vfp;

    assign instr    = xif.issue_instr[31:0];
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct6   = instr[31:26];
    assign width_ok = funct3 inside {3'b000, 3'b101, 3'b110, 3'b111};

`ifdef ARA_XIF_ISSUE_VCSR_EN
    localparam logic [6:0] OpcodeSystem = 7'h73;

    logic is_vcsr;
    logic csr_funct3_ok;

    assign csr_funct3_ok = funct3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    assign is_vcsr       = instr[31:20] inside {12'h008, 12'h009, 12'h00A, 12'h00F,
                                                12'hC20, 12'hC21, 12'hC22};
`endif

    always_comb begin
        dec_accept    = 1'b0;
        dec_writeback = 1'b0;
        dec_read      = 2'b00;
        dec_vfp       = 1'b0;
        case (opcode)
            OpcodeVec: begin
                dec_accept = 1'b1;
                case (funct3)
                    Opfvv: begin
                        dec_vfp       = 1'b1;
                        dec_writeback = (funct6 == 6'b010000);
                    end
                    Opmvv: dec_writeback = (funct6 == 6'b010000);
                    Opivx, Opmvx: dec_read[0] = 1'b1;
                    Opfvf: begin
                        dec_read[0] = 1'b1;
                        dec_vfp     = 1'b1;
                    end
                    Opcfg: begin
                        // vsetivli carries an immediate AVL, vsetvl also reads rs2
                        dec_read[0]   = (instr[31:30] != 2'b11);
                        dec_read[1]   = (instr[31:25] == 7'b1000000);
                        dec_writeback = 1'b1;
                    end
                    default: ;
                endcase
            end
            OpcodeLoadFp, OpcodeStoreFp: begin
                if (width_ok) begin
                    dec_accept  = 1'b1;
                    dec_read[0] = 1'b1;
                    dec_read[1] = (instr[27:26] == 2'b10);
                end
            end
            OpcodeAmo: begin
                if (width_ok) begin
                    dec_accept  = 1'b1;
                    dec_read[0] = 1'b1;
                end
            end
`ifdef ARA_XIF_ISSUE_VCSR_EN
            OpcodeSystem: begin
                if (csr_funct3_ok && is_vcsr) begin
                    dec_accept    = 1'b1;
                    dec_read      = 2'b11;
                    dec_writeback = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------------------------------
    // Queue storage
    // ---------------------------------------------------------------------------------------------
    entry_state_e          state_q [NrEntries];
    entry_state_e          state_d [NrEntries];
    logic [InstrWidth-1:0] instr_q [NrEntries];
    logic [IdWidth-1:0]    id_q    [NrEntries];
    logic                  vfp_q   [NrEntries];

    logic [PtrWidth-1:0] head_q, head_d;
    logic [PtrWidth-1:0] tail_q, tail_d;
    logic [CntWidth-1:0] occ_q, occ_d;
    logic                commit_err_q, commit_err_d;

    logic                dup_id;
    logic                commit_hit;
    logic [PtrWidth-1:0] commit_idx;
    logic                enq;
    logic                deq;
    entry_state_e        head_state;

    // Id lookups only see pre-cycle state, so a same-cycle enqueue is invisible to commit.
    always_comb begin
        dup_id     = 1'b0;
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int unsigned i = 0; i < NrEntries; i++) begin
            if ((state_q[i] != StFree) && (id_q[i] == xif.issue_id)) begin
                dup_id = 1'b1;
            end
            if ((state_q[i] == StWait) && (id_q[i] == xif.commit_id)) begin
                commit_hit = 1'b1;
                commit_idx = PtrWidth'(i);
            end
        end
    end

    assign head_state = state_q[head_q];

    assign xif.issue_ready         = (occ_q < CntWidth'(NrEntries));
    assign xif.issue_accept        = dec_accept & ~dup_id;
    assign xif.issue_writeback     = dec_writeback;
    assign xif.issue_register_read = dec_read;
    assign xif.issue_is_vfp        = dec_vfp;
    assign xif.commit_err          = commit_err_q;

    assign enq = xif.issue_valid & xif.issue_ready & xif.issue_accept;
    assign deq = ((head_state == StCommitted) & disp_ready_i) | (head_state == StKilled);

    assign disp_valid_o  = (head_state == StCommitted);
    assign disp_instr_o  = instr_q[head_q];
    assign disp_id_o     = id_q[head_q];
    assign disp_is_vfp_o = vfp_q[head_q];
    assign occupancy_o   = occ_q;

    // Commit only touches WAIT entries, dequeue only COMMITTED/KILLED at head, enqueue only the
    // FREE tail slot, so the three updates never target the same entry.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        commit_err_d = xif.commit_valid & ~commit_hit;
        if (xif.commit_valid && commit_hit) begin
            state_d[commit_idx] = xif.commit_kill ? StKilled : StCommitted;
        end
        if (deq) begin
            state_d[head_q] = StFree;
            head_d          = head_q + PtrWidth'(1);
        end
        if (enq) begin
            state_d[tail_q] = StWait;
            tail_d          = tail_q + PtrWidth'(1);
        end
        occ_d = occ_q + CntWidth'(enq) - CntWidth'(deq);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrEntries; i++) begin
                state_q[i] <= StFree;
            end
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            commit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            commit_err_q <= commit_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_q[tail_q] <= xif.issue_instr;
            id_q[tail_q]    <= xif.issue_id;
            vfp_q[tail_q]   <= dec_vfp;
        end
    end

endmodule
